big_ram_banked: RTL
===================

// Module: big_ram_banked
// PURPOSE
//   Parametrised dual-port Wishbone (pipelined) RAM. Replaces the fixed 2-bank, 2048x32 big_ram.
//   Ports A and B share NUM_BANKS single-ported banks, selected by the top address bits.
//   Both ports are served in the same cycle when they hit different banks.
//   A same-bank collision is arbitrated round-robin per bank, and the losing port is stalled.
//   Sits between the CPU/DMA Wishbone masters and on-chip memory.
// PARAMETERS
//   DATA_W    32  data width in bits; must be a multiple of 8
//   ADDR_W    11  word address width; total depth = 2**ADDR_W words
//   BANK_BITS 1   NUM_BANKS = 2**BANK_BITS; bank = addr[ADDR_W-1 -: BANK_BITS]; BANK_BITS < ADDR_W
//   SEL_W     DATA_W/8  byte-select width (derived, not overridable)
// PORTS
//   clk_i          in   1       single clock; all logic on rising edge
//   rst_i          in   1       synchronous, active-high reset
//   pA_wb_cyc_i    in   1       port A bus cycle
//   pA_wb_stb_i    in   1       port A strobe
//   pA_wb_we_i     in   1       port A write enable
//   pA_wb_addr_i   in   ADDR_W  port A word address
//   pA_wb_data_i   in   DATA_W  port A write data
//   pA_wb_sel_i    in   SEL_W   port A byte lane enables
//   pA_wb_ack_o    out  1       port A acknowledge
//   pA_wb_stall_o  out  1       port A stall
//   pA_wb_data_o   out  DATA_W  port A read data
//   pB_wb_*        (same set, same widths and meanings as port A, for port B)
// BEHAVIOUR
//   - Request: cyc_i & stb_i. It is accepted on a rising edge where request & !stall_o.
//   - Bank index = top BANK_BITS of addr. Word index = remaining ADDR_W-BANK_BITS bits.
//   - stall_o is combinational:
//       = 1 while rst_i is high;
//       = 1 when this port loses same-bank arbitration;
//       = 0 otherwise, including when there is no request.
//   - Arbitration (per bank): one last-winner flag per bank, reset to A.
//       On a collision the port that did not win the previous collision on that bank is granted.
//       The flag updates only on collisions.
//       The losing port holds its request and is served next cycle (it now holds priority).
//   - Latency: ack_o rises exactly 1 cycle after acceptance, for 1 cycle per accepted request.
//       Each port sustains 1 request per cycle; acks return in acceptance order.
//   - Write: lanes with sel_i[i]=1 are written at the acceptance edge. Other lanes are unchanged.
//       sel_i=0 is a no-op but is still acked. data_o is unchanged by writes.
//   - Read: data_o is valid with ack_o. It holds the last read value until the next read ack.
//       sel_i is ignored for reads; the full word is returned.
//   - Same-port write then read to the same address in consecutive cycles: the read returns the new data.
//   - Cross-port same-address access is always serialised by bank arbitration, so there is no hazard.
//   - If cyc_i drops after acceptance: the in-flight ack is still emitted and a write is already committed.
//   - Reset: all ack_o=0, data_o=0, all priority flags=A, all stall_o=1.
//       No request is accepted in a cycle with rst_i high. In-flight acks are dropped.
//       Memory contents are not cleared.
//   - Out-of-range addresses cannot occur (depth is a power of two).
// TESTING
//   1. Write A 0x004=DEADBEEF (sel F); read B 0x004 -> B ack 1 cycle after accept, data_o=DEADBEEF.
//   2. Same cycle: A writes 0x004=DEADBEEF, B writes 0x402=BEEFCAFE (different banks) ->
//      both stall=0, both ack next cycle; readback returns both values.
//   3. From reset, A reads 0x010 and B reads 0x020 in the same cycle (bank 0) ->
//      A accepted, B stalled 1 cycle, B ack 1 cycle after A. A repeat collision -> B wins.
//   4. Write 0x008=11223344 (sel F), then 0x008=AABBCCDD (sel 0101) -> read 0x008 = 11BB33DD.
//   5. A holds stb for 4 cycles, reading 0x000..0x003 preloaded with 1,2,3,4 ->
//      4 consecutive acks, data 1,2,3,4 in order, stall never asserted.
//   6. Assert rst_i during A's ack-pending cycle -> ack_o=0 and stall_o=1 during reset;
//      after reset, the earlier-written 0x004 still reads DEADBEEF.

Source files
------------

// File: rtl/big_ram_banked.sv
// Dual-port pipelined Wishbone RAM built from NUM_BANKS single-ported banks, bank = top address bits.
// Latency: ack_o one cycle after acceptance; each port sustains one request per cycle, acks in order.
// Backpressure: stall_o is combinational, high in reset and for the loser of a same-bank collision.
module big_ram_banked #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int BANK_BITS = 1,
  localparam int SEL_W    = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // port A
  input  logic              pA_wb_cyc_i,
  input  logic              pA_wb_stb_i,
  input  logic              pA_wb_we_i,
  input  logic [ADDR_W-1:0] pA_wb_addr_i,
  input  logic [DATA_W-1:0] pA_wb_data_i,
  input  logic [SEL_W-1:0]  pA_wb_sel_i,
  output logic              pA_wb_ack_o,
  output logic              pA_wb_stall_o,
  output logic [DATA_W-1:0] pA_wb_data_o,
  // port B
  input  logic              pB_wb_cyc_i,
  input  logic              pB_wb_stb_i,
  input  logic              pB_wb_we_i,
  input  logic [ADDR_W-1:0] pB_wb_addr_i,
  input  logic [DATA_W-1:0] pB_wb_data_i,
  input  logic [SEL_W-1:0]  pB_wb_sel_i,
  output logic              pB_wb_ack_o,
  output logic              pB_wb_stall_o,
  output logic [DATA_W-1:0] pB_wb_data_o
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int IDX_W     = ADDR_W - BANK_BITS;
  localparam int DEPTH     = 2 ** IDX_W;

  // request decode
  logic                 req_a, req_b;
  logic [BANK_BITS-1:0] bank_a, bank_b;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic                 collide;
  logic                 acc_a, acc_b;

  // per-bank priority: 1 means port B is granted at the next collision on that bank
  logic [NUM_BANKS-1:0] prio_b;

  // per-bank single-port access
  logic [NUM_BANKS-1:0]             bk_en;
  logic [NUM_BANKS-1:0]             bk_we;
  logic [IDX_W-1:0]                 bk_idx  [NUM_BANKS];
  logic [DATA_W-1:0]                bk_wdat [NUM_BANKS];
  logic [SEL_W-1:0]                 bk_sel  [NUM_BANKS];
  logic [NUM_BANKS-1:0][DATA_W-1:0] bk_rdat;

  // response pipeline, one stage per port
  logic                 ack_a_q, ack_b_q;
  logic                 rd_a_q, rd_b_q;
  logic [BANK_BITS-1:0] rbank_a_q, rbank_b_q;
  logic [DATA_W-1:0]    hold_a_q, hold_b_q;

  // Decode requests and resolve same-bank collisions; loser sees stall and holds its request.
  always_comb begin
    req_a   = pA_wb_cyc_i & pA_wb_stb_i;
    req_b   = pB_wb_cyc_i & pB_wb_stb_i;
    bank_a  = pA_wb_addr_i[ADDR_W-1 -: BANK_BITS];
    bank_b  = pB_wb_addr_i[ADDR_W-1 -: BANK_BITS];
    idx_a   = pA_wb_addr_i[IDX_W-1:0];
    idx_b   = pB_wb_addr_i[IDX_W-1:0];
    collide = req_a & req_b & (bank_a == bank_b);
    pA_wb_stall_o = rst_i | (collide &  prio_b[bank_a]);
    pB_wb_stall_o = rst_i | (collide & ~prio_b[bank_b]);
    acc_a = req_a & ~pA_wb_stall_o;
    acc_b = req_b & ~pB_wb_stall_o;
  end

  // Round-robin: after each collision the loser takes priority on that bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_b <= '0;
    end else if (collide) begin
      prio_b[bank_a] <= ~prio_b[bank_a];
    end
  end

  // Route each accepted request to its bank; arbitration guarantees at most one per bank.
  always_comb begin
    for (int g = 0; g < NUM_BANKS; g++) begin
      bk_en[g]   = 1'b0;
      bk_we[g]   = 1'b0;
      bk_idx[g]  = '0;
      bk_wdat[g] = '0;
      bk_sel[g]  = '0;
      if (acc_a && (bank_a == BANK_BITS'(g))) begin
        bk_en[g]   = 1'b1;
        bk_we[g]   = pA_wb_we_i;
        bk_idx[g]  = idx_a;
        bk_wdat[g] = pA_wb_data_i;
        bk_sel[g]  = pA_wb_sel_i;
      end else if (acc_b && (bank_b == BANK_BITS'(g))) begin
        bk_en[g]   = 1'b1;
        bk_we[g]   = pB_wb_we_i;
        bk_idx[g]  = idx_b;
        bk_wdat[g] = pB_wb_data_i;
        bk_sel[g]  = pB_wb_sel_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdat_q;

    // Byte-lane write or registered full-word read; contents survive reset.
    always_ff @(posedge clk_i) begin
      if (bk_en[g]) begin
        if (bk_we[g]) begin
          for (int i = 0; i < SEL_W; i++) begin
            if (bk_sel[g][i]) begin
              mem[bk_idx[g]][i*8 +: 8] <= bk_wdat[g][i*8 +: 8];
            end
          end
        end else begin
          rdat_q <= mem[bk_idx[g]];
        end
      end
    end

    assign bk_rdat[g] = rdat_q;
  end

  // Port A response stage: remember which bank answers, latch read data on the read ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_a_q   <= 1'b0;
      rd_a_q    <= 1'b0;
      rbank_a_q <= '0;
      hold_a_q  <= '0;
    end else begin
      ack_a_q <= acc_a;
      rd_a_q  <= acc_a & ~pA_wb_we_i;
      if (acc_a) begin
        rbank_a_q <= bank_a;
      end
      if (ack_a_q && rd_a_q) begin
        hold_a_q <= bk_rdat[rbank_a_q];
      end
    end
  end

  // Port B response stage, mirror of port A.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_b_q   <= 1'b0;
      rd_b_q    <= 1'b0;
      rbank_b_q <= '0;
      hold_b_q  <= '0;
    end else begin
      ack_b_q <= acc_b;
      rd_b_q  <= acc_b & ~pB_wb_we_i;
      if (acc_b) begin
        rbank_b_q <= bank_b;
      end
      if (ack_b_q && rd_b_q) begin
        hold_b_q <= bk_rdat[rbank_b_q];
      end
    end
  end

  // Outputs: an in-flight ack is suppressed while reset is high; data shows bank word on read ack, else held value.
  always_comb begin
    pA_wb_ack_o  = ack_a_q & ~rst_i;
    pB_wb_ack_o  = ack_b_q & ~rst_i;
    pA_wb_data_o = hold_a_q;
    pB_wb_data_o = hold_b_q;
    if (rst_i) begin
      pA_wb_data_o = '0;
      pB_wb_data_o = '0;
    end else begin
      if (ack_a_q && rd_a_q) begin
        pA_wb_data_o = bk_rdat[rbank_a_q];
      end
      if (ack_b_q && rd_b_q) begin
        pB_wb_data_o = bk_rdat[rbank_b_q];
      end
    end
  end

endmodule
